// File: rtl/complex_sync_fifo.sv
// Single-clock I/Q sample FIFO with separate I and Q memory banks, occupancy and threshold flags,
// synchronous flush and sticky error flags. Define COMPLEX_SYNC_FIFO_DEBUG_EN for ramp push / fixed-word pull.
module complex_sync_fifo #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 16,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
`ifdef COMPLEX_SYNC_FIFO_DEBUG_EN
  ,
  parameter logic [2*DATA_WIDTH-1:0] DEBUG_WORD = (2*DATA_WIDTH)'(32'hABCDEF01)
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_b_i,
  input  logic                    flush_i,
  input  logic                    wr_en_i,
  input  logic [2*DATA_WIDTH-1:0] wr_data_i,
  input  logic                    rd_en_i,
  input  logic                    clr_err_i,
`ifdef COMPLEX_SYNC_FIFO_DEBUG_EN
  input  logic                    debug_push_i,
  input  logic                    debug_pull_i,
`endif
  output logic [2*DATA_WIDTH-1:0] rd_data_o,
  output logic                    rd_valid_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic [ADDR_WIDTH:0]     level_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_LVL   = PW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = PW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_i_bank [DEPTH];
  logic [DATA_WIDTH-1:0] mem_q_bank [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                rd_valid_q, rd_valid_d;
  logic [2*DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  wr_acc, rd_acc;
  logic                  ovf_evt, unf_evt;
  logic [2*DATA_WIDTH-1:0] wr_word;
  logic [2*DATA_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

  assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  // Flush swallows both requests, so neither accepts nor counts as an error that cycle.
  assign rd_acc  = rd_en_i & ~empty_q & ~flush_i;
  assign wr_acc  = wr_en_i & (~full_q | rd_acc) & ~flush_i;
  assign ovf_evt = wr_en_i & ~wr_acc & ~flush_i;
  assign unf_evt = rd_en_i & ~rd_acc & ~flush_i;

  assign rd_word = {mem_i_bank[rd_addr], mem_q_bank[rd_addr]};

`ifdef COMPLEX_SYNC_FIFO_DEBUG_EN
  logic [DATA_WIDTH-1:0] ramp_cnt_q, ramp_cnt_d;

  always_comb begin
    ramp_cnt_d = ramp_cnt_q;
    if (wr_acc && debug_push_i) ramp_cnt_d = ramp_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) ramp_cnt_q <= '0;
    else          ramp_cnt_q <= ramp_cnt_d;
  end

  always_comb begin
    wr_word = wr_data_i;
    if (debug_push_i) wr_word = {ramp_cnt_q, ramp_cnt_q};
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_acc) rd_data_d = debug_pull_i ? DEBUG_WORD : rd_word;
  end
`else
  assign wr_word = wr_data_i;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_acc) rd_data_d = rd_word;
  end
`endif

  // Memory banks carry no reset so they can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_i_bank[wr_addr] <= wr_word[2*DATA_WIDTH-1:DATA_WIDTH];
      mem_q_bank[wr_addr] <= wr_word[DATA_WIDTH-1:0];
    end
  end

  // Flags come from the next level so they line up with the registered level_o.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d    = rd_ptr_q + PW'(rd_acc);
    level_d     = level_q + PW'(wr_acc) - PW'(rd_acc);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    full_d      = ~flush_i & (level_d == FULL_LVL);
    empty_d     = (level_d == '0);
    afull_d     = ~flush_i & (level_d >= AFULL_LVL);
    aempty_d    = flush_i | (level_d <= AEMPTY_LVL);
    overflow_d  = ovf_evt | (overflow_q & ~clr_err_i);
    underflow_d = unf_evt | (underflow_q & ~clr_err_i);
    rd_valid_d  = rd_acc;
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign level_o        = level_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_complex_sync_fifo.sv
// Directed bench for complex_sync_fifo at depth 8; the debug ramp/pull scenario runs only
// when COMPLEX_SYNC_FIFO_DEBUG_EN is defined.
module tb_complex_sync_fifo;

  logic        clk;
  logic        rstB;
  logic        flush;
  logic        wrEn;
  logic [31:0] wrData;
  logic        rdEn;
  logic        clrErr;
  logic [31:0] rdData;
  logic        rdValid;
  logic        full;
  logic        empty;
  logic        almostFull;
  logic        almostEmpty;
  logic [3:0]  level;
  logic        overflow;
  logic        underflow;
`ifdef COMPLEX_SYNC_FIFO_DEBUG_EN
  logic        debugPush;
  logic        debugPull;
`endif

  int checks = 0;
  int errors = 0;

  complex_sync_fifo #(
    .ADDR_WIDTH(3),
    .DATA_WIDTH(16),
    .AFULL_THRESH(4),
    .AEMPTY_THRESH(4)
  ) dut (
    .clk_i          (clk),
    .rst_b_i        (rstB),
    .flush_i        (flush),
    .wr_en_i        (wrEn),
    .wr_data_i      (wrData),
    .rd_en_i        (rdEn),
    .clr_err_i      (clrErr),
`ifdef COMPLEX_SYNC_FIFO_DEBUG_EN
    .debug_push_i   (debugPush),
    .debug_pull_i   (debugPull),
`endif
    .rd_data_o      (rdData),
    .rd_valid_o     (rdValid),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (almostFull),
    .almost_empty_o (almostEmpty),
    .level_o        (level),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns after it, where inputs are changed and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    flush  = 1'b0;
    wrEn   = 1'b0;
    wrData = '0;
    rdEn   = 1'b0;
    clrErr = 1'b0;
`ifdef COMPLEX_SYNC_FIFO_DEBUG_EN
    debugPush = 1'b0;
    debugPull = 1'b0;
`endif
  endtask

  task automatic test_reset();
    logic [12:0] got;
    logic [12:0] want;
    rstB = 1'b0;
    idleInputs();
    #12;
    got  = {rdValid, full, empty, almostFull, almostEmpty, level, overflow, underflow, 1'b0};
    want = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL reset_flags got %h want %h", got, want);
    end
    checks++;
    if (rdData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rd_data got %h want %h", rdData, 32'h0);
    end
    #4 rstB = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wrEn = 1'b1; wrData = 32'h1111_2222;
    tick();
    checks++;
    if (empty !== 1'b0 || level !== 4'd1) begin
      errors++;
      $display("[TB] FAIL single_after_write got empty=%b level=%0d want empty=0 level=1", empty, level);
    end
    wrEn = 1'b0; rdEn = 1'b1;
    tick();
    checks++;
    if (rdValid !== 1'b1 || rdData !== 32'h1111_2222) begin
      errors++;
      $display("[TB] FAIL single_read got valid=%b data=%h want valid=1 data=11112222", rdValid, rdData);
    end
    checks++;
    if (empty !== 1'b1 || level !== 4'd0) begin
      errors++;
      $display("[TB] FAIL single_empty got empty=%b level=%0d want empty=1 level=0", empty, level);
    end
    rdEn = 1'b0;
    tick();
    checks++;
    if (rdValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_strobe got valid=%b want 0", rdValid);
    end
  endtask

  task automatic test_fill_overflow();
    logic [3:0] wantFlags;
    for (int k = 0; k < 8; k++) begin
      wrEn = 1'b1; wrData = 32'hA000_0000 + k;
      tick();
      wantFlags = {(k == 7), 1'b0, (k + 1 >= 4), (k + 1 <= 4)};
      checks++;
      if (level !== 4'(k + 1) || {full, empty, almostFull, almostEmpty} !== wantFlags) begin
        errors++;
        $display("[TB] FAIL fill_%0d got level=%0d flags=%b want level=%0d flags=%b",
                 k, level, {full, empty, almostFull, almostEmpty}, k + 1, wantFlags);
      end
    end
    wrData = 32'hDEAD_DEAD;
    tick();
    checks++;
    if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_write got level=%0d full=%b ovf=%b want 8 1 1", level, full, overflow);
    end
    wrEn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rdEn = 1'b1;
      tick();
      checks++;
      if (rdValid !== 1'b1 || rdData !== 32'hA000_0000 + k || level !== 4'(7 - k)) begin
        errors++;
        $display("[TB] FAIL drain_%0d got valid=%b data=%h level=%0d want 1 %h %0d",
                 k, rdValid, rdData, level, 32'hA000_0000 + k, 7 - k);
      end
    end
    rdEn = 1'b0;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_empty got empty=%b full=%b want 1 0", empty, full);
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 8; k++) begin
      wrEn = 1'b1; wrData = 32'hB000_0000 + k;
      tick();
    end
    rdEn = 1'b1; wrData = 32'hBEEF_0008;
    tick();
    checks++;
    if (rdValid !== 1'b1 || rdData !== 32'hB000_0000 || level !== 4'd8 || full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_both got valid=%b data=%h level=%0d full=%b want 1 b0000000 8 1",
               rdValid, rdData, level, full);
    end
    wrEn = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (rdData !== ((k == 8) ? 32'hBEEF_0008 : 32'hB000_0000 + k)) begin
        errors++;
        $display("[TB] FAIL full_both_drain_%0d got %h want %h", k, rdData,
                 (k == 8) ? 32'hBEEF_0008 : 32'hB000_0000 + k);
      end
    end
    wrEn = 1'b1; wrData = 32'hC0DE_0001;
    tick();
    checks++;
    if (level !== 4'd1 || underflow !== 1'b1 || rdValid !== 1'b0 || rdData !== 32'hBEEF_0008) begin
      errors++;
      $display("[TB] FAIL empty_both got level=%0d unf=%b valid=%b data=%h want 1 1 0 beef0008",
               level, underflow, rdValid, rdData);
    end
    wrEn = 1'b0;
    tick();
    rdEn = 1'b0;
    checks++;
    if (rdData !== 32'hC0DE_0001 || level !== 4'd0) begin
      errors++;
      $display("[TB] FAIL empty_both_drain got data=%h level=%0d want c0de0001 0", rdData, level);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      wrEn = 1'b1; wrData = 32'hD000_0000 + k;
      tick();
    end
    checks++;
    if (level !== 4'd5) begin
      errors++;
      $display("[TB] FAIL flush_prefill got level=%0d want 5", level);
    end
    flush = 1'b1; wrData = 32'hFFFF_FFFF; rdEn = 1'b1;
    tick();
    flush = 1'b0; wrEn = 1'b0; rdEn = 1'b0;
    checks++;
    if (level !== 4'd0 || {full, empty, almostFull, almostEmpty} !== 4'b0101 || rdValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_state got level=%0d flags=%b valid=%b want 0 0101 0",
               level, {full, empty, almostFull, almostEmpty}, rdValid);
    end
    checks++;
    if (overflow !== 1'b1 || underflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_keeps_errors got ovf=%b unf=%b want 1 1", overflow, underflow);
    end
    clrErr = 1'b1;
    tick();
    clrErr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_err_both got ovf=%b unf=%b want 0 0", overflow, underflow);
    end
  endtask

  task automatic test_wrap();
    wrEn = 1'b1; wrData = 32'hE000_0000;
    tick();
    for (int k = 1; k < 20; k++) begin
      wrData = 32'hE000_0000 + k; rdEn = 1'b1;
      tick();
      checks++;
      if (rdValid !== 1'b1 || rdData !== 32'hE000_0000 + k - 1 || level !== 4'd1) begin
        errors++;
        $display("[TB] FAIL wrap_%0d got valid=%b data=%h level=%0d want 1 %h 1",
                 k, rdValid, rdData, level, 32'hE000_0000 + k - 1);
      end
    end
    wrEn = 1'b0;
    tick();
    rdEn = 1'b0;
    checks++;
    if (rdData !== 32'hE000_0013 || level !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_last got data=%h level=%0d ovf=%b unf=%b want e0000013 0 0 0",
               rdData, level, overflow, underflow);
    end
  endtask

  task automatic test_clr_err();
    rdEn = 1'b1;
    tick();
    checks++;
    if (underflow !== 1'b1 || rdValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underflow_set got unf=%b valid=%b want 1 0", underflow, rdValid);
    end
    clrErr = 1'b1;
    tick();
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_vs_event got unf=%b want 1", underflow);
    end
    rdEn = 1'b0;
    tick();
    clrErr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_alone got unf=%b want 0", underflow);
    end
  endtask

  task automatic test_async_reset();
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0; wrEn = 1'b1; wrData = 32'h5555_0000;
    tick();
    rdEn = 1'b1; wrData = 32'h5555_0001;
    tick();
    checks++;
    if (rdValid !== 1'b1 || rdData !== 32'h5555_0000 || underflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL burst_pre_reset got valid=%b data=%h unf=%b want 1 55550000 1",
               rdValid, rdData, underflow);
    end
    #3 rstB = 1'b0;
    #1;
    checks++;
    if ({rdValid, full, empty, almostFull, almostEmpty, level, overflow, underflow} !== 11'b0_0_1_0_1_0000_0_0) begin
      errors++;
      $display("[TB] FAIL async_reset_flags got %b want 00101000000",
               {rdValid, full, empty, almostFull, almostEmpty, level, overflow, underflow});
    end
    checks++;
    if (rdData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_data got %h want 0", rdData);
    end
    idleInputs();
    #2 rstB = 1'b1;
    tick();
  endtask

`ifdef COMPLEX_SYNC_FIFO_DEBUG_EN
  task automatic test_debug();
    logic [31:0] ramp [3];
    ramp[0] = 32'h0000_0000; ramp[1] = 32'h0001_0001; ramp[2] = 32'h0002_0002;
    for (int k = 0; k < 3; k++) begin
      wrEn = 1'b1; debugPush = 1'b1; wrData = 32'hFFFF_FFFF;
      tick();
    end
    wrEn = 1'b0; debugPush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rdEn = 1'b1;
      tick();
      checks++;
      if (rdData !== ramp[k]) begin
        errors++;
        $display("[TB] FAIL debug_ramp_%0d got %h want %h", k, rdData, ramp[k]);
      end
    end
    rdEn = 1'b0; wrEn = 1'b1; wrData = 32'h1234_5678;
    tick();
    wrEn = 1'b0; rdEn = 1'b1; debugPull = 1'b1;
    tick();
    rdEn = 1'b0; debugPull = 1'b0;
    checks++;
    if (rdData !== 32'hABCD_EF01 || rdValid !== 1'b1 || level !== 4'd0) begin
      errors++;
      $display("[TB] FAIL debug_pull got data=%h valid=%b level=%0d want abcdef01 1 0",
               rdData, rdValid, level);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simultaneous();
    test_flush();
    test_wrap();
    test_clr_err();
    test_async_reset();
`ifdef COMPLEX_SYNC_FIFO_DEBUG_EN
    test_debug();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
